// File: rtl/eq_gain_loader.sv
// Host byte writes land in a shadow gain table; changed bands are pushed to the
// equalizer one per clock, starting only at an audio sample boundary.
module eq_gain_loader #(
  parameter int          num_of_filters = 4,
  parameter logic [15:0] GAIN_RESET     = 16'h4000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      host_wr,
  input  logic [7:0]                host_addr,
  input  logic [7:0]                host_data,
  input  logic [7:0]                rd_addr,
  output logic [7:0]                rd_data,
  input  logic                      sample_en,
  output logic                      eq_wr,
  output logic [num_of_filters-1:0] eq_wr_sel,
  output logic [7:0]                eq_gain_lsb,
  output logic [7:0]                eq_gain_msb,
  output logic                      busy
);

  localparam int NF = num_of_filters;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t        state;
  logic [15:0]   shadow      [NF];
  logic [15:0]   commit_gain [NF];
  logic [NF-1:0] pending;
  logic [NF-1:0] commit_mask;
  logic [NF-1:0] lsb_we;
  logic [NF-1:0] msb_we;
  logic [NF-1:0] sel_idx;
  logic [NF-1:0] sel_onehot;
  logic [NF-1:0] mask_next;
  logic [15:0]   sel_gain;
  logic [7:0]    rd_byte;
  logic          start;

  // Band decode: band b owns bytes 2b/2b+1, anything else matches no band.
  always_comb begin
    lsb_we = '0;
    msb_we = '0;
    for (int i = 0; i < NF; i++) begin
      if (host_wr && host_addr[7:1] == 7'(i)) begin
        if (host_addr[0]) msb_we[i] = 1'b1;
        else              lsb_we[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NF; i++) begin
      if (rd_addr[7:1] == 7'(i))
        rd_byte = rd_addr[0] ? shadow[i][15:8] : shadow[i][7:0];
    end
  end

  // Lowest set bit of the in-flight mask wins; scanning downward leaves it last.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    sel_gain   = '0;
    for (int i = NF - 1; i >= 0; i--) begin
      if (commit_mask[i]) begin
        sel_idx    = NF'(i);
        sel_onehot = '0;
        sel_onehot[i] = 1'b1;
        sel_gain   = commit_gain[i];
      end
    end
  end

  assign mask_next = commit_mask & ~sel_onehot;
  assign start     = (state == IDLE) && sample_en && (pending != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '1;
      commit_mask <= '0;
      for (int i = 0; i < NF; i++) begin
        shadow[i]      <= GAIN_RESET;
        commit_gain[i] <= GAIN_RESET;
      end
      eq_wr       <= 1'b0;
      eq_wr_sel   <= '0;
      eq_gain_lsb <= '0;
      eq_gain_msb <= '0;
      busy        <= 1'b0;
      rd_data     <= '0;
    end else begin
      rd_data <= rd_byte;

      for (int i = 0; i < NF; i++) begin
        if (lsb_we[i]) shadow[i][7:0]  <= host_data;
        if (msb_we[i]) shadow[i][15:8] <= host_data;
      end

      // A same-cycle MSB write misses the snapshot, so its pending bit survives.
      pending <= (start ? '0 : pending) | msb_we;

      case (state)
        IDLE: begin
          eq_wr <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            commit_mask <= pending;
            for (int i = 0; i < NF; i++) commit_gain[i] <= shadow[i];
            state <= COMMIT;
          end
        end
        COMMIT: begin
          eq_wr       <= 1'b1;
          busy        <= 1'b1;
          eq_wr_sel   <= sel_idx;
          eq_gain_lsb <= sel_gain[7:0];
          eq_gain_msb <= sel_gain[15:8];
          commit_mask <= mask_next;
          if (mask_next == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_gain_loader.sv
// Scoreboard bench for eq_gain_loader: a posedge model queues expected gain
// writes with their due cycle, a negedge monitor pops and compares them.
module tb_eq_gain_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_wr;
  logic [7:0] host_addr;
  logic [7:0] host_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       sample_en;
  logic       eq_wr;
  logic [3:0] eq_wr_sel;
  logic [7:0] eq_gain_lsb;
  logic [7:0] eq_gain_msb;
  logic       busy;

  eq_gain_loader #(.num_of_filters(4), .GAIN_RESET(16'h4000)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_wr     (host_wr),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sample_en   (sample_en),
    .eq_wr       (eq_wr),
    .eq_wr_sel   (eq_wr_sel),
    .eq_gain_lsb (eq_gain_lsb),
    .eq_gain_msb (eq_gain_msb),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  sel;
    logic [15:0] gain;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] m_shadow [4];
  logic [3:0]  m_pending;
  logic [3:0]  m_set;
  int          m_band;
  int          m_slot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model; a non-empty queue at an edge means a commit is in flight.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int i = 0; i < 4; i++) m_shadow[i] = 16'h4000;
      m_pending = 4'hF;
      sb.delete();
    end else begin
      m_set  = 4'h0;
      m_band = int'(host_addr[7:1]);
      if (host_wr && host_addr < 8'd8 && host_addr[0]) m_set[m_band] = 1'b1;
      if (sample_en && sb.size() == 0 && m_pending != 4'h0) begin
        m_slot = 0;
        for (int b = 0; b < 4; b++) begin
          if (m_pending[b]) begin
            m_slot++;
            sb.push_back('{cyc: cyc + m_slot, sel: 4'(b), gain: m_shadow[b]});
          end
        end
        m_pending = 4'h0;
      end
      m_pending = m_pending | m_set;
      if (host_wr && host_addr < 8'd8) begin
        if (host_addr[0]) m_shadow[m_band][15:8] = host_data;
        else              m_shadow[m_band][7:0]  = host_data;
      end
    end
  end

  always @(negedge clk) begin
    if (eq_wr) begin
      if (sb.size() == 0) begin
        chk("unexpected_wr", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_sel", 32'(eq_wr_sel), 32'(mon_e.sel));
        chk("wr_lsb", 32'(eq_gain_lsb), 32'(mon_e.gain[7:0]));
        chk("wr_msb", 32'(eq_gain_msb), 32'(mon_e.gain[15:8]));
        chk("wr_busy", 32'(busy), 32'd1);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      chk("wr_missing", 32'd0, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_wr   = 1'b1;
    host_addr = a;
    host_data = d;
    tick();
    host_wr   = 1'b0;
  endtask

  task automatic pulse_sample();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    tick();
    chk({tag, "_idle_wr"}, 32'(eq_wr), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    reset     = 1'b1;
    host_wr   = 1'b0;
    host_addr = 8'h00;
    host_data = 8'h00;
    rd_addr   = 8'h00;
    sample_en = 1'b0;
    repeat (3) tick();

    chk("rst_eq_wr", 32'(eq_wr), 32'd0);
    chk("rst_sel", 32'(eq_wr_sel), 32'd0);
    chk("rst_lsb", 32'(eq_gain_lsb), 32'd0);
    chk("rst_msb", 32'(eq_gain_msb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    reset = 1'b0;
    tick();

    // all four reset gains go out on the first boundary
    pulse_sample();
    drain("boot");
    chk("hold_sel", 32'(eq_wr_sel), 32'd3);
    chk("hold_lsb", 32'(eq_gain_lsb), 32'h00);
    chk("hold_msb", 32'(eq_gain_msb), 32'h40);
    read_chk("rd_band0_msb", 8'h01, 8'h40);

    host_write(8'h02, 8'h34);
    host_write(8'h03, 8'h12);
    pulse_sample();
    drain("band1");
    read_chk("rd_addr3", 8'h03, 8'h12);
    read_chk("rd_addr2", 8'h02, 8'h34);

    host_write(8'h07, 8'hAA);
    host_write(8'h01, 8'h55);
    pulse_sample();
    drain("b0_b3");

    // 4-band commit with a host write and an ignored boundary in flight
    host_write(8'h01, 8'h11);
    host_write(8'h03, 8'h22);
    host_write(8'h05, 8'h33);
    host_write(8'h07, 8'h44);
    pulse_sample();
    tick();
    host_write(8'h01, 8'h7F);
    pulse_sample();
    drain("inflight");
    pulse_sample();
    drain("after_inflight");
    read_chk("rd_addr1", 8'h01, 8'h7F);

    host_write(8'h20, 8'h99);
    host_write(8'h08, 8'h99);
    pulse_sample();
    repeat (5) tick();
    chk("oor_no_wr", 32'(eq_wr), 32'd0);
    read_chk("rd_oor20", 8'h20, 8'h00);
    read_chk("rd_oor08", 8'h08, 8'h00);

    // reset lands on the second write cycle of a 4-band commit
    host_write(8'h01, 8'hA1);
    host_write(8'h03, 8'hA3);
    host_write(8'h05, 8'hA5);
    host_write(8'h07, 8'hA7);
    pulse_sample();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("abort_eq_wr", 32'(eq_wr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    read_chk("rd_after_abort", 8'h07, 8'h40);
    pulse_sample();
    drain("post_reset");

    pulse_sample();
    repeat (3) tick();
    chk("nopend_no_wr", 32'(eq_wr), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
